// File: rtl/edsac_timing_pkg.sv
// EDSAC timing generator shared types: FSM state encoding and default geometry.
// No logic, no latency, no flow control.
package edsac_timing_pkg;
    localparam int DEF_DIGITS_PER_MINOR = 18;
    localparam int DEF_MINORS_PER_MAJOR = 16;

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        ARMED    = 2'd1,
        RUNNING  = 2'd2,
        STOPPING = 2'd3
    } timing_state_e;
endpackage

// File: rtl/edsac_timing_counter.sv
// Prescaler -> digit -> minor-cycle cascade; wrap/boundary flags describe the NEXT clk.
// Free-running, zero-latency decode of registered counts, no backpressure.
module edsac_timing_counter
    import edsac_timing_pkg::*;
#(
    parameter int DIGITS_PER_MINOR = DEF_DIGITS_PER_MINOR,
    parameter int MINORS_PER_MAJOR = DEF_MINORS_PER_MAJOR,
    parameter int CLKS_PER_DIGIT   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [$clog2(DIGITS_PER_MINOR)-1:0] d_pos,
    output logic [$clog2(MINORS_PER_MAJOR)-1:0] minor_idx,
    output logic                                digit_wrap,
    output logic                                major_wrap,
    output logic                                d17_next,
    output logic                                b_evt
);
    localparam int PW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int DW = $clog2(DIGITS_PER_MINOR);
    localparam int MW = $clog2(MINORS_PER_MAJOR);

    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] d_q, d_d;
    logic [MW-1:0] m_q, m_d;
    logic          pre_wrap;

    always_comb begin
        pre_wrap   = (pre_q == PW'(CLKS_PER_DIGIT - 1));
        digit_wrap = pre_wrap && (d_q == DW'(DIGITS_PER_MINOR - 1));
        major_wrap = digit_wrap && (m_q == MW'(MINORS_PER_MAJOR - 1));
        // Next clk is the first clk of the last digit position.
        d17_next   = pre_wrap && (d_q == DW'(DIGITS_PER_MINOR - 2));
        // End of an odd minor cycle: the next clk opens a long word.
        b_evt      = digit_wrap && m_q[0];

        pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        d_d   = d_q;
        m_d   = m_q;
        if (pre_wrap) begin
            d_d = digit_wrap ? '0 : d_q + DW'(1);
        end
        if (digit_wrap) begin
            m_d = major_wrap ? '0 : m_q + MW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            d_q   <= '0;
            m_q   <= '0;
        end else begin
            pre_q <= pre_d;
            d_q   <= d_d;
            m_q   <= m_d;
        end
    end

    assign d_pos     = d_q;
    assign minor_idx = m_q;
endmodule

// File: rtl/edsac_timing_gen.sv
// EDSAC master timing: free-running digit/minor counters plus long-word-aligned strobe gating.
// Strobes are registered (1 clk wide); optional single-word step under `TIMING_STEP_EN.
module edsac_timing_gen
    import edsac_timing_pkg::*;
#(
    parameter int DIGITS_PER_MINOR = DEF_DIGITS_PER_MINOR,
    parameter int MINORS_PER_MAJOR = DEF_MINORS_PER_MAJOR,
    parameter int CLKS_PER_DIGIT   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                run,
    input  logic                                step,
    output logic [$clog2(DIGITS_PER_MINOR)-1:0] d_pos,
    output logic [$clog2(MINORS_PER_MAJOR)-1:0] minor_idx,
    output logic                                odd_minor,
    output logic                                major_start,
    output logic                                ev_d0,
    output logic                                odd_d0,
    output logic                                d17,
    output logic                                gated
);
    if (MINORS_PER_MAJOR % 2 != 0) begin : g_bad_minors
        $error("MINORS_PER_MAJOR must be even");
    end

    logic          digit_wrap, major_wrap, d17_next, b_evt;
    timing_state_e state_q, state_d;
    logic          step_req, step_arm;
    logic          major_start_q, ev_d0_q, odd_d0_q, d17_q;
    logic          major_start_d, ev_d0_d, odd_d0_d, d17_d, gated_d;

    edsac_timing_counter #(
        .DIGITS_PER_MINOR (DIGITS_PER_MINOR),
        .MINORS_PER_MAJOR (MINORS_PER_MAJOR),
        .CLKS_PER_DIGIT   (CLKS_PER_DIGIT)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .d_pos      (d_pos),
        .minor_idx  (minor_idx),
        .digit_wrap (digit_wrap),
        .major_wrap (major_wrap),
        .d17_next   (d17_next),
        .b_evt      (b_evt)
    );

`ifdef TIMING_STEP_EN
    logic step_q, step_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step_d;
    end

    always_comb begin
        step_d = step_q;
        if (state_q == HALTED && !run && step) step_d = 1'b1;
        else if (state_q != ARMED)             step_d = 1'b0;
        else if (b_evt)                        step_d = 1'b0;
    end

    assign step_req = step;
    assign step_arm = step_q;
`else
    logic step_unused;
    assign step_unused = step;
    assign step_req    = 1'b0;
    assign step_arm    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HALTED;
            major_start_q <= 1'b0;
            ev_d0_q       <= 1'b0;
            odd_d0_q      <= 1'b0;
            d17_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            major_start_q <= major_start_d;
            ev_d0_q       <= ev_d0_d;
            odd_d0_q      <= odd_d0_d;
            d17_q         <= d17_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:   if (run || step_req) state_d = ARMED;
            // A stepped arm ignores run and delivers one word via STOPPING.
            ARMED:    if (step_arm) begin
                          if (b_evt) state_d = STOPPING;
                      end else if (!run) begin
                          state_d = HALTED;
                      end else if (b_evt) begin
                          state_d = RUNNING;
                      end
            RUNNING:  if (!run) state_d = STOPPING;
            STOPPING: if (run) state_d = RUNNING;
                      else if (b_evt) state_d = HALTED;
            default:  state_d = HALTED;
        endcase
    end

    // Strobes are decoded one clk early and registered, so they align with the counters.
    always_comb begin
        gated_d       = (state_d == RUNNING) || (state_d == STOPPING);
        major_start_d = major_wrap;
        ev_d0_d       = gated_d && b_evt;
        odd_d0_d      = gated_d && digit_wrap && !minor_idx[0];
        d17_d         = gated_d && d17_next;
    end

    assign odd_minor   = minor_idx[0];
    assign major_start = major_start_q;
    assign ev_d0       = ev_d0_q;
    assign odd_d0      = odd_d0_q;
    assign d17         = d17_q;
    assign gated       = (state_q == RUNNING) || (state_q == STOPPING);
endmodule
